muldiv_sequencer: RTL and testbench

Iterative unsigned multiply/divide unit for the execute stage. It implements MULTU and DIVU by running the existing 32-bit ALU once per cycle for 32 cycles, and leaves the 64-bit result in HI/LO. The ALU stays purely combinational. This block is its sequencer: it owns `alu_a`, `alu_b` and `alu_control` while an operation runs, and the top level muxes these onto the ALU during `busy`.

---
 rtl/alu_pkg.sv | 18 +
 rtl/muldiv_sequencer.sv | 131 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, multiply/divide op select and the
// multiply/divide sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic OpMultu = 1'b0;
  localparam logic OpDivu  = 1'b1;

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StRun  = 2'b01;
  localparam logic [1:0] StDone = 2'b10;

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative MULTU/DIVU sequencer: drives the shared 32-bit ALU once per cycle for
// 32 cycles and accumulates the 64-bit result in hi/lo.
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [4:0] LastStep = 5'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             op_q, op_d;
  logic [4:0]       count_q, count_d;
  logic             busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

  logic [WIDTH-1:0] shifted;
  logic             carry, borrow, ge;

  assign shifted = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign carry   = alu_result < hi_q;
  assign borrow  = alu_result > shifted;
  assign ge      = hi_q[WIDTH-1] | ~borrow;

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = AluAdd;
    if (state_q == StRun) begin
      if (op_q == OpDivu) begin
        alu_control = AluSub;
        alu_a       = shifted;
        alu_b       = operand_q;
      end else begin
        alu_a = hi_q;
        alu_b = lo_q[0] ? operand_q : '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    operand_d  = operand_q;
    op_d       = op_q;
    count_d    = count_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      StRun: begin
        if (op_q == OpDivu) begin
          hi_d = ge ? alu_result : shifted;
          lo_d = {lo_q[WIDTH-2:0], ge};
        end else begin
          // Right shift of the 65-bit {carry, sum, lo}.
          hi_d = {carry, alu_result[WIDTH-1:1]};
          lo_d = {alu_result[0], lo_q[WIDTH-1:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == LastStep) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        if (start) begin
          state_d    = StRun;
          hi_d       = '0;
          lo_d       = op ? operand_a : operand_b;
          operand_d  = op ? operand_b : operand_a;
          op_d       = op;
          count_d    = '0;
          div_zero_d = op & (operand_b == '0);
        end
      end
    endcase
  end

  assign busy_d = state_d == StRun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hi_q       <= '0;
      lo_q       <= '0;
      operand_q  <= '0;
      op_q       <= OpMultu;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      operand_q  <= operand_d;
      op_q       <= op_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer with a behavioural ALU and a 64-bit arithmetic
// reference model for MULTU/DIVU results.
module tb_muldiv_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;

  int n_checks = 0;
  int n_fail = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_zero   (div_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_control)
      AluAnd:  alu_result = alu_a & alu_b;
      AluOr:   alu_result = alu_a | alu_b;
      AluAdd:  alu_result = alu_a + alu_b;
      AluSub:  alu_result = alu_a - alu_b;
      AluSlt:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; divide by zero gives all-ones quotient.
  function automatic logic [64:0] model(input logic o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    if (o == OpMultu) begin
      p = {32'd0, a} * {32'd0, b};
      return {1'b0, p};
    end
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    return {1'b0, a % b, a / b};
  endfunction

  task automatic start_op(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("alu_ctl_run", {61'd0, alu_control}, {61'd0, (o == OpDivu) ? AluSub : AluAdd});
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic check_result(input string tag, input logic o, input logic [31:0] a,
                              input logic [31:0] b, input int cycles, input int exp_cycles);
    logic [64:0] m;
    m = model(o, a, b);
    chk({tag, "_latency"}, 64'(cycles), 64'(exp_cycles));
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, m[63:0]);
    chk({tag, "_divz"}, {63'd0, div_zero}, {63'd0, m[64]});
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                        input logic [31:0] b);
    int cyc;
    start_op(o, a, b);
    wait_done(cyc);
    check_result(tag, o, a, b, cyc + 1, 33);
  endtask

  task automatic check_pulse_end(input string tag, input logic [63:0] exp_hilo);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_held"}, {hi, lo}, exp_hilo);
  endtask

  initial begin
    int          cyc;
    logic        o;
    logic [31:0] a, b;
    logic [64:0] m;

    #12;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_alu", {alu_a, alu_b}, 64'd0);
    chk("idle_ctl", {61'd0, alu_control}, {61'd0, AluAdd});

    // start_op returns one edge after start; wait_done counts the rest.
    run_op("mul_7x6", OpMultu, 32'd7, 32'd6);
    check_pulse_end("mul_7x6", 64'd42);
    run_op("mul_ffxff", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_100_7", OpDivu, 32'd100, 32'd7);
    run_op("div_msb", OpDivu, 32'h8000_0000, 32'd3);
    chk("div_msb_q", {32'd0, lo}, 64'h2AAA_AAAA);
    run_op("div_zero", OpDivu, 32'd5, 32'd0);
    chk("div_zero_flag", {63'd0, div_zero}, 64'd1);
    check_pulse_end("div_zero", {32'd5, 32'hFFFF_FFFF});
    chk("div_zero_hold", {63'd0, div_zero}, 64'd1);
    run_op("mul_2x3", OpMultu, 32'd2, 32'd3);

    // start while busy must be ignored.
    start_op(OpMultu, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op = OpDivu;
    operand_a = 32'd99;
    operand_b = 32'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignore_busy", {63'd0, busy}, 64'd1);
    wait_done(cyc);
    check_result("ignore", OpMultu, 32'd3, 32'd4, cyc + 11, 33);

    // Chain a DIVU from the DONE cycle.
    start_op(OpDivu, 32'd9, 32'd2);
    wait_done(cyc);
    check_result("chain", OpDivu, 32'd9, 32'd2, cyc + 1, 33);

    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      start_op(o, a, b);
      wait_done(cyc);
      check_result("rand", o, a, b, cyc + 1, 33);
      m = model(o, a, b);
      if ($urandom_range(0, 1) == 1) check_pulse_end("rand", m[63:0]);
    end

    // Asynchronous reset mid-run.
    start_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("areset_busy", {63'd0, busy}, 64'd0);
    chk("areset_done", {63'd0, done}, 64'd0);
    chk("areset_hilo", {hi, lo}, 64'd0);
    chk("areset_alu", {alu_a, alu_b}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_busy", {63'd0, busy}, 64'd0);
    chk("post_reset_done", {63'd0, done}, 64'd0);
    chk("post_reset_alu", {alu_a, alu_b}, 64'd0);
    chk("post_reset_ctl", {61'd0, alu_control}, {61'd0, AluAdd});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
